// File: rtl/hdc_pkg.sv
// Shared hypervector types and binder enumerations for the HDC encoding datapath.
package hdc_pkg;

  localparam int unsigned HV_DIM = 1024;

  typedef logic [HV_DIM-1:0] hv_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } bind_state_e;

  typedef enum logic {
    ROT_RIGHT = 1'b0,
    ROT_LEFT  = 1'b1
  } rot_dir_e;

endpackage

// File: rtl/hv_rotate_step.sv
// Combinational cyclic rotator for amounts 0..STEP, built as one barrel stage per amount bit.
module hv_rotate_step #(
  parameter int unsigned HV_DIM = hdc_pkg::HV_DIM,
  parameter int unsigned STEP   = 64,
  localparam int unsigned AMT_W = $clog2(STEP + 1)
) (
  input  logic [HV_DIM-1:0] hv,
  input  logic [AMT_W-1:0]  amount,
  input  logic              dir,
  output logic [HV_DIM-1:0] rotated
);

  logic [HV_DIM-1:0] cur;

  // Rotate by a fixed distance; left moves bit i to i+r, right moves bit i to i-r.
  function automatic logic [HV_DIM-1:0] rot_by(input logic [HV_DIM-1:0] x,
                                                input int unsigned       r,
                                                input logic              left);
    logic [2*HV_DIM-1:0] dbl;
    dbl = {x, x};
    if (left) begin
      dbl = dbl << r;
      return dbl[2*HV_DIM-1:HV_DIM];
    end
    dbl = dbl >> r;
    return dbl[HV_DIM-1:0];
  endfunction

  // Stage k rotates by 2^k (mod HV_DIM) when amount bit k is set.
  always_comb begin
    cur = hv;
    for (int k = 0; k < int'(AMT_W); k++) begin
      if (amount[k]) cur = rot_by(cur, (32'd1 << k) % HV_DIM, dir);
    end
    rotated = cur;
  end

endmodule

// File: rtl/seq_binder.sv
// Multi-cycle handshaked binder: rotates a hypervector by a runtime amount, at most STEP bits per cycle.
module seq_binder #(
  parameter int unsigned HV_DIM  = hdc_pkg::HV_DIM,
  parameter int unsigned STEP    = 64,
  parameter int unsigned SHIFT_W = $clog2(HV_DIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [HV_DIM-1:0]  level_hv,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic               dir,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [HV_DIM-1:0]  shifted_hv,
  output logic               busy
);

  import hdc_pkg::bind_state_e;
  import hdc_pkg::IDLE;
  import hdc_pkg::ROTATE;
  import hdc_pkg::DONE;
  import hdc_pkg::rot_dir_e;
  import hdc_pkg::ROT_RIGHT;

  localparam int unsigned AMT_W = $clog2(STEP + 1);
  localparam logic [SHIFT_W:0] DIM_X  = (SHIFT_W + 1)'(HV_DIM);
  localparam logic [SHIFT_W:0] STEP_X = (SHIFT_W + 1)'(STEP);

  bind_state_e        state;
  logic [SHIFT_W-1:0] rem;
  rot_dir_e           rot_dir;

  logic [SHIFT_W:0]   amt_x;
  logic [SHIFT_W-1:0] rem_load_c;
  logic [AMT_W-1:0]   step_c;
  logic [SHIFT_W-1:0] rem_next_c;
  logic [HV_DIM-1:0]  rot_hv;

  assign in_ready = (state == IDLE) && en;

  // shift_amt < 2*HV_DIM, so one conditional subtract reduces it mod HV_DIM.
  assign amt_x = {1'b0, shift_amt};
  always_comb begin
    rem_load_c = shift_amt;
    if (amt_x >= DIM_X) rem_load_c = SHIFT_W'(amt_x - DIM_X);
  end

  // Per-cycle step is min(rem, STEP).
  always_comb begin
    step_c = AMT_W'(rem);
    if ({1'b0, rem} >= STEP_X) step_c = AMT_W'(STEP);
  end

  assign rem_next_c = rem - SHIFT_W'(step_c);

  hv_rotate_step #(
    .HV_DIM (HV_DIM),
    .STEP   (STEP)
  ) u_rot (
    .hv      (shifted_hv),
    .amount  (step_c),
    .dir     (rot_dir),
    .rotated (rot_hv)
  );

  // Control FSM; the result register doubles as the rotation working register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      rot_dir    <= ROT_RIGHT;
      shifted_hv <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && en) begin
            shifted_hv <= level_hv;
            rem        <= rem_load_c;
            rot_dir    <= rot_dir_e'(dir);
            busy       <= 1'b1;
            if (rem_load_c != '0) begin
              state <= ROTATE;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        ROTATE: begin
          if (en) begin
            shifted_hv <= rot_hv;
            rem        <= rem_next_c;
            if (rem_next_c == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // Result handshake completes independently of en.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_binder.sv
// Scoreboard bench for seq_binder: directed requests push expected results, a monitor checks outputs.
module tb_seq_binder;
  import hdc_pkg::*;

  localparam int unsigned STEP    = 64;
  localparam int unsigned SHIFT_W = $clog2(HV_DIM);

  typedef struct {
    hv_t hv;
    int  lat;
    int  acc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst, en, in_valid, in_ready, dir;
  logic               out_valid, out_ready, busy;
  hv_t                level_hv, shifted_hv;
  logic [SHIFT_W-1:0] shift_amt;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb[$];

  hv_t hv5, exp5;

  seq_binder #(
    .HV_DIM  (HV_DIM),
    .STEP    (STEP),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .level_hv   (level_hv),
    .shift_amt  (shift_amt),
    .dir        (dir),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .shifted_hv (shifted_hv),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_hv(input string name, input hv_t act, input hv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got[63:0]=%h expected[63:0]=%h differing_bits=%0d",
               name, act[63:0], exp[63:0], $countones(act ^ exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a request, wait (bounded) for acceptance; optionally push the expected result.
  task automatic send(input hv_t hv, input int amt, input bit d, input bit track,
                      input hv_t exp_hv, input int exp_lat);
    int n;
    exp_t e;
    n         = 0;
    level_hv  = hv;
    shift_amt = SHIFT_W'(amt);
    dir       = d;
    in_valid  = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_int("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (track) begin
      e.hv  = exp_hv;
      e.lat = exp_lat;
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) check_int("idle_timeout", 0, 1);
  endtask

  // Monitor: pops on first presentation of each result, then checks it stays stable until taken.
  initial begin : monitor
    bit   seen;
    hv_t  held;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            check_int("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            check_hv("result", shifted_hv, e.hv);
            check_int("latency", cyc - e.acc, e.lat);
          end
          seen = 1'b1;
          held = shifted_hv;
        end else begin
          check_hv("hold_stable", shifted_hv, held);
        end
        if (out_ready) seen = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst       = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    level_hv  = '0;
    shift_amt = '0;
    dir       = 1'b0;
    out_ready = 1'b1;
    hv5       = hv_t'(64'h8000_0000_0000_0003);
    exp5      = hv_t'(68'h1_0000_0000_0000_0006);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_hv("reset_shifted_hv", shifted_hv, '0);
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    // Right by 1: bit 0 wraps to bit 1023
    send(hv_t'(1), 1, 1'b0, 1'b1, hv_t'(1) << 1023, 1);
    wait_idle();
    check_hv("idle_keeps_result", shifted_hv, hv_t'(1) << 1023);

    // Left by 200 in steps 64,64,64,8
    send(hv_t'(1), 200, 1'b1, 1'b1, hv_t'(1) << 200, 4);
    repeat (4) begin
      @(negedge clk);
      check_int("busy_during_rotate", int'(busy), 1);
    end
    wait_idle();

    // Zero shift passes the input straight through
    send(hv_t'(8'hA5), 0, 1'b0, 1'b1, hv_t'(8'hA5), 0);
    wait_idle();

    // Right by 1023 equals left by 1
    send(hv5, 1023, 1'b0, 1'b1, exp5, 16);
    wait_idle();
    send(hv5, 1, 1'b1, 1'b1, exp5, 1);
    wait_idle();

    // Sink stall: result held with out_ready low
    out_ready = 1'b0;
    send(hv_t'(1) << 10, 4, 1'b0, 1'b1, hv_t'(1) << 6, 1);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check_int("stall_out_valid", int'(out_valid), 1);
      check_int("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // Enable low for 3 cycles in ROTATE: right by 200 takes 4+3 edges
    send(hv_t'(1), 200, 1'b0, 1'b1, hv_t'(1) << 824, 7);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    wait_idle();

    // Abort in the second ROTATE cycle; no result may appear
    send(hv_t'(1), 200, 1'b1, 1'b0, '0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_out_valid", int'(out_valid), 0);
    check_hv("abort_shifted_hv", shifted_hv, '0);
    send(hv_t'(1) << 3, 2, 1'b1, 1'b1, hv_t'(1) << 5, 1);
    wait_idle();

    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
